brc_arbiter: RTL and testbench

Shares the single branch comparator (`brc`) between two requesters: port 0 (branch unit, conditional-branch resolution) and port 1 (ALU set-less-than path). The block arbitrates round-robin, registers the winning operands, sequences one comparison through `brc`, decodes the funct3-style opcode into a 1-bit result, and returns it to the granted port over a valid/ready handshake.

---
 rtl/brc_pkg.sv | 22 ++
 rtl/brc_arbiter_if.sv | 31 +++
 rtl/brc.sv | 11 +
 rtl/rr_arb2.sv | 31 +++
 rtl/brc_arbiter.sv | 128 ++++++++++++
 tb/tb_brc_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/brc_pkg.sv
// Shared types and constants for the branch-comparator arbiter slice.
package brc_pkg;

    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned OP_WIDTH  = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_EQ  = 3'b000,
        OP_NE  = 3'b001,
        OP_LT  = 3'b100,
        OP_GE  = 3'b101,
        OP_LTU = 3'b110,
        OP_GEU = 3'b111
    } cmp_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        RSP
    } arb_state_e;

endpackage

// File: rtl/brc_arbiter_if.sv
// Request/response bundle between the two requesters and brc_arbiter.
interface brc_arbiter_if
    import brc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 5,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic [NUM_PORTS-1:0]                 i_req_valid;
    logic [NUM_PORTS-1:0]                 o_req_ready;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] i_req_rs1;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] i_req_rs2;
    logic [NUM_PORTS-1:0][OP_WIDTH-1:0]   i_req_op;
    logic [NUM_PORTS-1:0][TAG_WIDTH-1:0]  i_req_tag;
    logic [NUM_PORTS-1:0]                 o_rsp_valid;
    logic [NUM_PORTS-1:0]                 i_rsp_ready;
    logic                                 o_rsp_result;
    logic                                 o_rsp_illegal;
    logic [TAG_WIDTH-1:0]                 o_rsp_tag;
    logic [CNT_WIDTH-1:0]                 o_conflict_cnt;

    modport slave (
        input  i_req_valid, i_req_rs1, i_req_rs2, i_req_op, i_req_tag, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_illegal, o_rsp_tag, o_conflict_cnt
    );

    modport master (
        output i_req_valid, i_req_rs1, i_req_rs2, i_req_op, i_req_tag, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_illegal, o_rsp_tag, o_conflict_cnt
    );
endinterface

// File: rtl/brc.sv
// 32-bit branch comparator: equality plus signed/unsigned less-than.
module brc (
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic        i_br_un,
    output logic        o_br_eq,
    output logic        o_br_lt
);
    assign o_br_eq = (i_rs1 == i_rs2);
    assign o_br_lt = i_br_un ? (i_rs1 < i_rs2) : ($signed(i_rs1) < $signed(i_rs2));
endmodule

// File: rtl/rr_arb2.sv
// Two-port round-robin grant; the last winner loses the next tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant_c
);
    logic last_grant;

    always_comb begin
        grant_c = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant_c = 2'b01;
                2'b10:   grant_c = 2'b10;
                2'b11:   grant_c = last_grant ? 2'b01 : 2'b10;
                default: grant_c = 2'b00;
            endcase
        end
    end

    // Reset to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (|grant_c) begin
            last_grant <= grant_c[1];
        end
    end
endmodule

// File: rtl/brc_arbiter.sv
// Shares one brc comparator between the branch unit (port 0) and the ALU
// set-less-than path (port 1): arbitrate, compare, return a 1-bit result.
module brc_arbiter
    import brc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 5,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,
    brc_arbiter_if.slave  bus
);
    arb_state_e                state_q, state_d;
    logic [NUM_PORTS-1:0]      grant_c;
    logic                      accept_c;
    logic                      owner_c;

    logic [DATA_WIDTH-1:0]     rs1_q, rs2_q;
    logic [OP_WIDTH-1:0]       op_q;
    logic [TAG_WIDTH-1:0]      tag_q;
    logic                      owner_q;

    logic                      br_eq_c, br_lt_c;
    logic                      result_c, illegal_c;

    logic [NUM_PORTS-1:0]      rsp_valid_q;
    logic                      rsp_result_q, rsp_illegal_q;
    logic [TAG_WIDTH-1:0]      rsp_tag_q;
    logic [CNT_WIDTH-1:0]      cnt_q;

    rr_arb2 u_rr_arb2 (
        .clk     (i_clk),
        .reset   (i_reset),
        .en      (state_q == IDLE),
        .req     (bus.i_req_valid),
        .grant_c (grant_c)
    );

    assign bus.o_req_ready = grant_c;
    assign accept_c        = |(grant_c & bus.i_req_valid);
    assign owner_c         = grant_c[1];

    brc u_brc (
        .i_rs1   (rs1_q),
        .i_rs2   (rs2_q),
        .i_br_un (op_q[1]),
        .o_br_eq (br_eq_c),
        .o_br_lt (br_lt_c)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = CMP;
            CMP:     state_d = RSP;
            RSP:     if (bus.i_rsp_ready[owner_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rs1_q   <= '0;
            rs2_q   <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            owner_q <= 1'b0;
        end else if (accept_c) begin
            rs1_q   <= bus.i_req_rs1[owner_c];
            rs2_q   <= bus.i_req_rs2[owner_c];
            op_q    <= bus.i_req_op[owner_c];
            tag_q   <= bus.i_req_tag[owner_c];
            owner_q <= owner_c;
        end
    end

    // funct3 decode; the 01x codes have no comparison meaning.
    always_comb begin
        result_c  = 1'b0;
        illegal_c = 1'b0;
        case (cmp_op_e'(op_q))
            OP_EQ:         result_c  = br_eq_c;
            OP_NE:         result_c  = ~br_eq_c;
            OP_LT, OP_LTU: result_c  = br_lt_c;
            OP_GE, OP_GEU: result_c  = ~br_lt_c;
            default:       illegal_c = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rsp_valid_q   <= '0;
            rsp_result_q  <= 1'b0;
            rsp_illegal_q <= 1'b0;
            rsp_tag_q     <= '0;
        end else if (state_q == CMP) begin
            rsp_valid_q   <= {owner_q, ~owner_q};
            rsp_result_q  <= result_c;
            rsp_illegal_q <= illegal_c;
            rsp_tag_q     <= tag_q;
        end else if ((state_q == RSP) && bus.i_rsp_ready[owner_q]) begin
            rsp_valid_q   <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if ((state_q == IDLE) && (&bus.i_req_valid) && !(&cnt_q)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.o_rsp_valid    = rsp_valid_q;
    assign bus.o_rsp_result   = rsp_result_q;
    assign bus.o_rsp_illegal  = rsp_illegal_q;
    assign bus.o_rsp_tag      = rsp_tag_q;
    assign bus.o_conflict_cnt = cnt_q;
endmodule

// File: tb/tb_brc_arbiter.sv
// Bench for brc_arbiter: directed scenarios plus random traffic against a
// transaction-level model; a 4-bit-counter twin shows counter saturation.
module tb_brc_arbiter;
    import brc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    brc_arbiter_if #(.DATA_WIDTH(32), .TAG_WIDTH(5), .CNT_WIDTH(16)) bus ();
    brc_arbiter_if #(.DATA_WIDTH(32), .TAG_WIDTH(5), .CNT_WIDTH(4))  bus_s ();

    brc_arbiter #(.DATA_WIDTH(32), .TAG_WIDTH(5), .CNT_WIDTH(16)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    brc_arbiter #(.DATA_WIDTH(32), .TAG_WIDTH(5), .CNT_WIDTH(4)) dut_s (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus_s)
    );

    assign bus_s.i_req_valid = bus.i_req_valid;
    assign bus_s.i_req_rs1   = bus.i_req_rs1;
    assign bus_s.i_req_rs2   = bus.i_req_rs2;
    assign bus_s.i_req_op    = bus.i_req_op;
    assign bus_s.i_req_tag   = bus.i_req_tag;
    assign bus_s.i_rsp_ready = bus.i_rsp_ready;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: compare semantics straight from the opcode table; returns {illegal, result}.
    function automatic logic [1:0] golden(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return {1'b0, a == b};
            3'b001:  return {1'b0, a != b};
            3'b100:  return {1'b0, $signed(a) < $signed(b)};
            3'b101:  return {1'b0, $signed(a) >= $signed(b)};
            3'b110:  return {1'b0, a < b};
            3'b111:  return {1'b0, a >= b};
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] exp_grant(input logic [1:0] v, input bit last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    // Transaction model: a request occupies the comparator from acceptance until
    // its response is taken; the response appears one edge after acceptance.
    bit          chk_en = 1'b0;
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    bit          m_owner = 1'b0;
    bit          m_last = 1'b1;
    logic [1:0]  m_rv   = 2'b00;
    bit          m_res  = 1'b0;
    bit          m_ill  = 1'b0;
    logic [4:0]  m_tag  = 5'd0;
    bit          p_res, p_ill;
    logic [4:0]  p_tag;
    int          m_cnt   = 0;
    int          m_cnt_s = 0;

    always @(posedge clk) begin
        logic [1:0] g;
        if (rst) begin
            m_busy = 1'b0; m_age = 0; m_last = 1'b1; m_rv = 2'b00;
            m_res = 1'b0; m_ill = 1'b0; m_tag = 5'd0; m_cnt = 0; m_cnt_s = 0;
            chk_en = 1'b1;
        end else if (!m_busy) begin
            g = exp_grant(bus.i_req_valid, m_last);
            if (bus.i_req_valid == 2'b11) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_s < 15) m_cnt_s++;
            end
            if (g != 2'b00) begin
                m_owner = g[1];
                m_last  = g[1];
                {p_ill, p_res} = golden(bus.i_req_op[g[1]], bus.i_req_rs1[g[1]], bus.i_req_rs2[g[1]]);
                p_tag   = bus.i_req_tag[g[1]];
                m_busy  = 1'b1;
                m_age   = 0;
            end
        end else begin
            m_age++;
            if (m_age == 1) begin
                m_rv  = m_owner ? 2'b10 : 2'b01;
                m_res = p_res; m_ill = p_ill; m_tag = p_tag;
            end else if (bus.i_rsp_ready[m_owner]) begin
                m_busy = 1'b0;
                m_rv   = 2'b00;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_ready", 32'(bus.o_req_ready), 32'(m_busy ? 2'b00 : exp_grant(bus.i_req_valid, m_last)));
            check("rsp_valid", 32'(bus.o_rsp_valid), 32'(m_rv));
            check("rsp_result", 32'(bus.o_rsp_result), 32'(m_res));
            check("rsp_illegal", 32'(bus.o_rsp_illegal), 32'(m_ill));
            check("rsp_tag", 32'(bus.o_rsp_tag), 32'(m_tag));
            check("conflict_cnt", 32'(bus.o_conflict_cnt), 32'(m_cnt));
            check("conflict_cnt_small", 32'(bus_s.o_conflict_cnt), 32'(m_cnt_s));
            check("rsp_valid_small", 32'(bus_s.o_rsp_valid), 32'(m_rv));
        end
    end

    task automatic set_req(input int p, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag);
        bus.i_req_op[p]  = op;
        bus.i_req_rs1[p] = a;
        bus.i_req_rs2[p] = b;
        bus.i_req_tag[p] = tag;
    endtask

    task automatic new_payload(input int p);
        logic [31:0] a, b;
        a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom();
        b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom();
        set_req(p, 3'($urandom_range(0, 7)), a, b, 5'($urandom_range(0, 31)));
    endtask

    // Wait (bounded) until port p is granted, then let the next edge accept it.
    task automatic wait_grant(input int p, input string nm);
        int n = 0;
        @(negedge clk);
        while (!bus.o_req_ready[p] && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_granted"}, 32'(bus.o_req_ready[p]), 32'd1);
        @(posedge clk); #1;
        bus.i_req_valid[p] = 1'b0;
    endtask

    task automatic send(input int p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic exp_res, input logic exp_ill, input string nm);
        logic [1:0] onehot;
        onehot = (p == 1) ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        set_req(p, op, a, b, tag);
        bus.i_req_valid[p] = 1'b1;
        bus.i_rsp_ready    = 2'b11;
        wait_grant(p, nm);
        check({nm, "_cmp_novalid"}, 32'(bus.o_rsp_valid), 32'd0);
        @(posedge clk); #1;
        check({nm, "_valid"}, 32'(bus.o_rsp_valid), 32'(onehot));
        check({nm, "_result"}, 32'(bus.o_rsp_result), 32'(exp_res));
        check({nm, "_illegal"}, 32'(bus.o_rsp_illegal), 32'(exp_ill));
        check({nm, "_tag"}, 32'(bus.o_rsp_tag), 32'(tag));
        @(posedge clk); #1;
        check({nm, "_done"}, 32'(bus.o_rsp_valid), 32'd0);
    endtask

    initial begin
        logic [1:0] gr;
        int acc[2];
        int order[$];
        int gcyc[$];
        int cyc;
        bit cnt_seen;

        bus.i_req_valid = 2'b00;
        bus.i_rsp_ready = 2'b00;
        set_req(0, 3'b000, 32'd0, 32'd0, 5'd0);
        set_req(1, 3'b000, 32'd0, 32'd0, 5'd0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        check("reset_cnt", 32'(bus.o_conflict_cnt), 32'd0);
        check("reset_tag", 32'(bus.o_rsp_tag), 32'd0);

        send(0, 3'b100, 32'hFFFF_FFFE, 32'h0000_0001, 5'd3, 1'b1, 1'b0, "signed_lt");
        send(1, 3'b110, 32'hFFFF_FFFE, 32'h0000_0001, 5'd7, 1'b0, 1'b0, "ltu");
        send(1, 3'b101, 32'hFFFF_FFFE, 32'h0000_0001, 5'd8, 1'b0, 1'b0, "ge");
        send(1, 3'b000, 32'd5, 32'd5, 5'd9, 1'b1, 1'b0, "eq");
        send(0, 3'b010, 32'd5, 32'd5, 5'd10, 1'b0, 1'b1, "illegal");
        send(1, 3'b001, 32'd1, 32'd2, 5'd11, 1'b1, 1'b0, "after_illegal");

        // Continuous conflict: 4 requests per port, responses taken at once.
        acc = '{0, 0};
        cyc = 0;
        cnt_seen = 1'b0;
        @(posedge clk); #1;
        new_payload(0);
        new_payload(1);
        bus.i_req_valid = 2'b11;
        bus.i_rsp_ready = 2'b11;
        while ((acc[0] < 4 || acc[1] < 4) && cyc < 200) begin
            @(negedge clk);
            gr = bus.o_req_ready & bus.i_req_valid;
            @(posedge clk); #1;
            cyc++;
            for (int p = 0; p < 2; p++) begin
                if (gr[p]) begin
                    order.push_back(p);
                    gcyc.push_back(cyc);
                    acc[p]++;
                    if (acc[p] == 4) bus.i_req_valid[p] = 1'b0;
                    else new_payload(p);
                end
            end
            if (order.size() == 4 && !cnt_seen) begin
                check("conflict_cnt_after4", 32'(bus.o_conflict_cnt), 32'd4);
                cnt_seen = 1'b1;
            end
        end
        check("conflict_all_granted", 32'(acc[0] + acc[1]), 32'd8);
        for (int i = 0; i < 4; i++)
            check("rr_order", (i < order.size()) ? 32'(order[i]) : 32'd99, 32'(i % 2));
        for (int i = 1; i < 4; i++)
            check("rr_spacing", (i < gcyc.size()) ? 32'(gcyc[i] - gcyc[i-1]) : 32'd99, 32'd3);
        repeat (3) @(posedge clk);

        // Backpressure on port 0; the non-owner ready bit is held high and must be ignored.
        #1;
        bus.i_rsp_ready = 2'b10;
        set_req(0, 3'b110, 32'd3, 32'd7, 5'd21);
        bus.i_req_valid[0] = 1'b1;
        wait_grant(0, "bp");
        new_payload(1);
        bus.i_req_valid[1] = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", 32'(bus.o_rsp_valid), 32'd1);
            check("bp_result", 32'(bus.o_rsp_result), 32'd1);
            check("bp_tag", 32'(bus.o_rsp_tag), 32'd21);
            check("bp_req_ready", 32'(bus.o_req_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.i_rsp_ready = 2'b01;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(bus.o_rsp_valid), 32'd0);
        check("bp_release_idle_grant", 32'(bus.o_req_ready), 32'd2);
        @(posedge clk); #1;
        bus.i_req_valid[1] = 1'b0;
        bus.i_rsp_ready = 2'b11;
        repeat (3) @(posedge clk);

        // Reset while a port-0 response is pending: no response, port 0 wins next tie.
        #1;
        bus.i_rsp_ready = 2'b00;
        set_req(0, 3'b000, 32'd4, 32'd4, 5'd17);
        bus.i_req_valid[0] = 1'b1;
        wait_grant(0, "rst_mid");
        @(posedge clk); #1;
        check("rst_mid_pending", 32'(bus.o_rsp_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_valid", 32'(bus.o_rsp_valid), 32'd0);
        check("rst_mid_cnt", 32'(bus.o_conflict_cnt), 32'd0);
        rst = 1'b0;
        new_payload(0);
        new_payload(1);
        bus.i_req_valid = 2'b11;
        @(negedge clk);
        check("rst_mid_first_tie", 32'(bus.o_req_ready), 32'd1);

        // Random traffic; requesters hold valid and payload until accepted.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            gr = bus.i_req_valid & bus.o_req_ready;
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (gr[p] || !bus.i_req_valid[p]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        new_payload(p);
                        bus.i_req_valid[p] = 1'b1;
                    end else begin
                        bus.i_req_valid[p] = 1'b0;
                    end
                end
            end
            bus.i_rsp_ready = 2'($urandom_range(0, 3));
            rst = (c < 2500) && ($urandom_range(0, 199) == 0);
        end

        // Sustained conflict long enough to pin the 4-bit twin at all-ones.
        rst = 1'b0;
        bus.i_rsp_ready = 2'b11;
        for (int c = 0; c < 75; c++) begin
            @(negedge clk);
            gr = bus.i_req_valid & bus.o_req_ready;
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (gr[p] || !bus.i_req_valid[p]) begin
                    new_payload(p);
                    bus.i_req_valid[p] = 1'b1;
                end
            end
        end
        @(negedge clk);
        check("cnt_saturated", 32'(bus_s.o_conflict_cnt), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
